// File: rtl/nn_pkg.sv
// Shared neuron datapath definitions: default Q-format widths, accumulator sizing,
// saturation helper and the MAC control states.
package nn_pkg;

  localparam int DATA_BITS = 16;
  localparam int FRAC_BITS = 8;

  typedef enum logic {
    ACCUM,
    DRAIN
  } state_t;

  // Wide enough that num_weights full-scale products can never overflow.
  function automatic int acc_width(input int data_bits, input int num_weights);
    return 2 * data_bits + $clog2(num_weights);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int bits);
    logic signed [63:0] max_val;
    logic signed [63:0] min_val;
    max_val = (64'sd1 <<< (bits - 1)) - 64'sd1;
    min_val = -(64'sd1 <<< (bits - 1));
    if (value > max_val) return max_val;
    if (value < min_val) return min_val;
    return value;
  endfunction

endpackage

// File: rtl/neuron_act.sv
// Combinational output stage: drops the fractional bits of the biased sum,
// clamps to the output range and optionally applies ReLU.
module neuron_act
  import nn_pkg::*;
#(
  parameter int data_bits = DATA_BITS,
  parameter int frac_bits = FRAC_BITS,
  parameter int sum_bits  = 40,
  parameter int act_relu  = 1
) (
  input  logic signed [sum_bits-1:0]  sum,
  output logic signed [data_bits-1:0] result
);

  logic signed [63:0] wide;
  logic signed [63:0] shifted;
  logic signed [63:0] clamped;

  always_comb begin
    wide    = 64'(sum);
    shifted = wide >>> frac_bits;
    clamped = saturate(shifted, data_bits);
    result  = clamped[data_bits-1:0];
    if ((act_relu != 0) && (clamped < 0)) result = '0;
  end

endmodule

// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate: align, multiply, accumulate over one vector,
// then bias, shift, saturate and activate into a single result strobe.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int    data_bits   = DATA_BITS,
  parameter int    frac_bits   = FRAC_BITS,
  parameter int    num_weights = 784,
  parameter int    layer_no    = 0,
  parameter int    neuron_no   = 0,
  parameter int    act_relu    = 1,
  parameter string bias_file   = "pretrained_bias.mif"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 neuron_in_valid,
  input  logic [data_bits-1:0] neuron_in,
  input  logic [data_bits-1:0] weight_out,
  input  logic                 bias_valid,
  input  logic [31:0]          bias_value,
  input  logic [31:0]          config_layer_no,
  input  logic [31:0]          config_neuron_no,
  output logic                 in_ready,
  output logic [data_bits-1:0] neuron_out,
  output logic                 output_valid,
  output logic                 overrun
);

  localparam int acc_bits = acc_width(data_bits, num_weights);
  localparam int sum_bits = acc_bits + 1;
  localparam int cnt_bits = (num_weights > 1) ? $clog2(num_weights) : 1;
  localparam logic [cnt_bits-1:0] last_idx = cnt_bits'(num_weights - 1);

  state_t state;
  state_t state_next;

  logic                          accept;
  logic [cnt_bits-1:0]           in_cnt;
  logic                          s1_valid;
  logic signed [data_bits-1:0]   s1_in;
  logic                          s2_valid;
  logic signed [2*data_bits-1:0] s2_prod;
  logic signed [acc_bits-1:0]    acc;
  logic [cnt_bits-1:0]           prod_cnt;
  logic                          last;
  logic signed [data_bits-1:0]   bias_reg;
  logic signed [sum_bits-1:0]    sum;
  logic signed [data_bits-1:0]   act_result;
  logic                          unused_bits;

  assign accept = neuron_in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && (in_cnt == last_idx)) state_next = DRAIN;
      end
      DRAIN: begin
        if (output_valid) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // Counts accepted samples so the FSM knows when the vector is complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt <= '0;
    end else if (accept) begin
      in_cnt <= (in_cnt == last_idx) ? '0 : in_cnt + cnt_bits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_in    <= '0;
      s2_valid <= 1'b0;
      s2_prod  <= '0;
    end else begin
      s1_valid <= accept;
      s1_in    <= $signed(neuron_in);
      s2_valid <= s1_valid;
      s2_prod  <= s1_in * $signed(weight_out);
    end
  end

  // Accumulation never overlaps the clearing cycle thanks to the DRAIN spacing.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      prod_cnt <= '0;
      last     <= 1'b0;
    end else begin
      last <= 1'b0;
      if (s2_valid) begin
        acc <= acc + acc_bits'(s2_prod);
        if (prod_cnt == last_idx) begin
          last     <= 1'b1;
          prod_cnt <= '0;
        end else begin
          prod_cnt <= prod_cnt + cnt_bits'(1);
        end
      end else if (last) begin
        acc <= '0;
      end
    end
  end

  always_comb begin
    sum = sum_bits'(acc) + (sum_bits'(bias_reg) <<< frac_bits);
  end

  neuron_act #(
    .data_bits(data_bits),
    .frac_bits(frac_bits),
    .sum_bits (sum_bits),
    .act_relu (act_relu)
  ) u_act (
    .sum   (sum),
    .result(act_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      neuron_out   <= '0;
      output_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      output_valid <= last;
      overrun      <= neuron_in_valid & ~in_ready;
      if (last) neuron_out <= act_result;
    end
  end

`ifdef pretrained
  // Bias is fixed at load time; the config bus is ignored.
  logic [data_bits-1:0] bias_mem [0:0];
  initial bias_mem[0] = '0;
  assign bias_reg    = $signed(bias_mem[0]);
  assign unused_bits = ^{bias_valid, bias_value, config_layer_no, config_neuron_no};
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      bias_reg <= '0;
    end else if (bias_valid && (config_layer_no == 32'(layer_no)) &&
                 (config_neuron_no == 32'(neuron_no))) begin
      bias_reg <= $signed(bias_value[data_bits-1:0]);
    end
  end
  assign unused_bits = ^bias_value[31:data_bits];
`endif

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: a ReLU and a linear instance share one
// stimulus stream and a weight memory model, checked against an arithmetic reference.
module tb_neuron_mac;

  localparam int DB     = 16;
  localparam int FB     = 8;
  localparam int NW     = 4;
  localparam int LAYER  = 1;
  localparam int NEURON = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        bias_valid;
  logic [31:0] bias_value;
  logic [31:0] cfg_layer;
  logic [31:0] cfg_neuron;

  logic        in_ready_r, ov_r, overrun_r;
  logic        in_ready_l, ov_l, overrun_l;
  logic [15:0] out_r, out_l;
  logic [15:0] weight_r, weight_l;

  logic [15:0] wmem [NW];
  int          addr_r, addr_l;
  logic [15:0] bias_model;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  int          mon_cyc_r[$], mon_cyc_l[$];
  logic [15:0] mon_val_r[$], mon_val_l[$];
  int          ovr_cnt_r, ovr_cnt_l;
  int          exp_cyc[$];
  logic [15:0] exp_r[$], exp_l[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  neuron_mac #(
    .data_bits(DB), .frac_bits(FB), .num_weights(NW), .layer_no(LAYER),
    .neuron_no(NEURON), .act_relu(1), .bias_file("pretrained_bias.mif")
  ) dut_relu (
    .clk(clk), .reset(reset), .neuron_in_valid(in_valid), .neuron_in(in_data),
    .weight_out(weight_r), .bias_valid(bias_valid), .bias_value(bias_value),
    .config_layer_no(cfg_layer), .config_neuron_no(cfg_neuron),
    .in_ready(in_ready_r), .neuron_out(out_r), .output_valid(ov_r), .overrun(overrun_r)
  );

  neuron_mac #(
    .data_bits(DB), .frac_bits(FB), .num_weights(NW), .layer_no(LAYER),
    .neuron_no(NEURON), .act_relu(0), .bias_file("pretrained_bias.mif")
  ) dut_lin (
    .clk(clk), .reset(reset), .neuron_in_valid(in_valid), .neuron_in(in_data),
    .weight_out(weight_l), .bias_valid(bias_valid), .bias_value(bias_value),
    .config_layer_no(cfg_layer), .config_neuron_no(cfg_neuron),
    .in_ready(in_ready_l), .neuron_out(out_l), .output_valid(ov_l), .overrun(overrun_l)
  );

  // Weight memory control: read on every offered sample, rewind on result or reset.
  always @(posedge clk) begin
    if (reset || ov_r) addr_r <= 0;
    else if (in_valid) begin
      weight_r <= wmem[addr_r % NW];
      addr_r   <= addr_r + 1;
    end
    if (reset || ov_l) addr_l <= 0;
    else if (in_valid) begin
      weight_l <= wmem[addr_l % NW];
      addr_l   <= addr_l + 1;
    end
  end

  always @(negedge clk) begin
    if (ov_r === 1'b1) begin mon_val_r.push_back(out_r); mon_cyc_r.push_back(cyc); end
    if (ov_l === 1'b1) begin mon_val_l.push_back(out_l); mon_cyc_l.push_back(cyc); end
    if (overrun_r === 1'b1) ovr_cnt_r++;
    if (overrun_l === 1'b1) ovr_cnt_l++;
  end

  function automatic logic [15:0] model(input logic [15:0] ins[NW], input logic [15:0] ws[NW],
                                        input logic [15:0] bias, input bit relu);
    longint total;
    total = 0;
    for (int i = 0; i < NW; i++)
      total += longint'($signed(ins[i])) * longint'($signed(ws[i]));
    total += longint'($signed(bias)) * (longint'(1) << FB);
    total = total >>> FB;
    if (total > 32767) total = 32767;
    if (total < -32768) total = -32768;
    if (relu && total < 0) total = 0;
    return 16'(total);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tracking;
    mon_cyc_r.delete(); mon_cyc_l.delete(); mon_val_r.delete(); mon_val_l.delete();
    exp_cyc.delete(); exp_r.delete(); exp_l.delete();
    ovr_cnt_r = 0; ovr_cnt_l = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    bias_model = 16'h0000;
    clear_tracking();
  endtask

  task automatic set_bias(input logic [15:0] value, input int layer, input int neuron);
    bias_valid = 1'b1;
    bias_value = {16'hA5C3, value};
    cfg_layer  = 32'(layer);
    cfg_neuron = 32'(neuron);
    tick;
    bias_valid = 1'b0;
    if (layer == LAYER && neuron == NEURON) bias_model = value;
  endtask

  task automatic fill_weights(input logic [15:0] w);
    for (int i = 0; i < NW; i++) wmem[i] = w;
  endtask

  task automatic send_vector(input logic [15:0] ins[NW], input int max_gap,
                             input logic [15:0] exp_bias, output int t_last);
    int gap;
    t_last = 0;
    for (int i = 0; i < NW; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) tick;
      in_valid = 1'b1;
      in_data  = ins[i];
      t_last   = cyc;
      tick;
      in_valid = 1'b0;
    end
    exp_cyc.push_back(t_last + 4);
    exp_r.push_back(model(ins, wmem, exp_bias, 1'b1));
    exp_l.push_back(model(ins, wmem, exp_bias, 1'b0));
  endtask

  task automatic check_scoreboard(input string name, input int exp_ovr);
    repeat (8) tick;
    n_checks++;
    if (mon_cyc_r.size() != exp_cyc.size() || mon_cyc_l.size() != exp_cyc.size())
      $display("[TB] FAIL %s result count: got %0d/%0d expected %0d", name,
               mon_cyc_r.size(), mon_cyc_l.size(), exp_cyc.size());
    else n_pass++;
    for (int i = 0; i < exp_cyc.size(); i++) begin
      if (i < mon_cyc_r.size() && i < mon_cyc_l.size()) begin
        n_checks++;
        if (mon_cyc_r[i] !== exp_cyc[i] || mon_cyc_l[i] !== exp_cyc[i])
          $display("[TB] FAIL %s timing[%0d]: got cycle %0d/%0d expected %0d", name, i,
                   mon_cyc_r[i], mon_cyc_l[i], exp_cyc[i]);
        else n_pass++;
        n_checks++;
        if (mon_val_r[i] !== exp_r[i])
          $display("[TB] FAIL %s relu[%0d]: got %h expected %h", name, i, mon_val_r[i], exp_r[i]);
        else n_pass++;
        n_checks++;
        if (mon_val_l[i] !== exp_l[i])
          $display("[TB] FAIL %s linear[%0d]: got %h expected %h", name, i, mon_val_l[i], exp_l[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (ovr_cnt_r !== exp_ovr || ovr_cnt_l !== exp_ovr)
      $display("[TB] FAIL %s overrun pulses: got %0d/%0d expected %0d", name,
               ovr_cnt_r, ovr_cnt_l, exp_ovr);
    else n_pass++;
    clear_tracking();
  endtask

  task automatic check_value(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    check_value("reset in_ready", {15'd0, in_ready_r & in_ready_l}, 16'h0001);
    check_value("reset neuron_out", out_r | out_l, 16'h0000);
    check_value("reset output_valid", {15'd0, ov_r | ov_l}, 16'h0000);
    check_value("reset overrun", {15'd0, overrun_r | overrun_l}, 16'h0000);
    reset = 1'b0;
    bias_model = 16'h0000;
    clear_tracking();
  endtask

  task automatic test_basic;
    logic [15:0] ins[NW] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    int t;
    fill_weights(16'h0100);
    set_bias(16'h0080, LAYER, NEURON);
    send_vector(ins, 0, bias_model, t);
    check_value("drain in_ready", {15'd0, in_ready_r}, 16'h0000);
    while (cyc < t + 4) tick;
    check_value("basic valid at T+4", {15'd0, ov_r}, 16'h0001);
    check_value("basic value", out_r, 16'h0A80);
    tick;
    check_value("basic valid width", {15'd0, ov_r}, 16'h0000);
    check_value("in_ready at T+5", {15'd0, in_ready_r}, 16'h0001);
    check_scoreboard("basic", 0);
  endtask

  task automatic test_sign;
    logic [15:0] ins[NW] = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
    int t;
    fill_weights(16'h0100);
    set_bias(16'h0000, LAYER, NEURON);
    send_vector(ins, 0, bias_model, t);
    check_scoreboard("sign", 0);
    check_value("sign relu", out_r, 16'h0000);
    check_value("sign linear", out_l, 16'hFC00);
  endtask

  task automatic test_saturate;
    logic [15:0] pos[NW] = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    logic [15:0] neg[NW] = '{16'h8100, 16'h8100, 16'h8100, 16'h8100};
    int t;
    fill_weights(16'h7F00);
    send_vector(pos, 0, bias_model, t);
    check_scoreboard("sat pos", 0);
    check_value("sat pos relu", out_r, 16'h7FFF);
    check_value("sat pos linear", out_l, 16'h7FFF);
    send_vector(neg, 0, bias_model, t);
    check_scoreboard("sat neg", 0);
    check_value("sat neg linear", out_l, 16'h8000);
  endtask

  task automatic test_gaps;
    logic [15:0] ins[NW] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    int t;
    fill_weights(16'h0100);
    set_bias(16'h0080, LAYER, NEURON);
    for (int k = 0; k < 3; k++) begin
      send_vector(ins, 3, bias_model, t);
      check_scoreboard("gaps", 0);
      check_value("gaps value", out_r, 16'h0A80);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a[NW] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    logic [15:0] b[NW];
    int t;
    for (int i = 0; i < NW; i++) b[i] = 16'($urandom_range(0, 2048)) - 16'd1024;
    send_vector(a, 0, bias_model, t);
    while (cyc < t + 5) tick;
    send_vector(b, 0, bias_model, t);
    check_scoreboard("back_to_back", 0);
  endtask

  task automatic test_overrun;
    logic [15:0] ins[NW] = '{16'h0040, 16'hFF80, 16'h0300, 16'h0120};
    int t;
    send_vector(ins, 0, bias_model, t);
    in_valid = 1'b1; in_data = 16'h7777;
    tick;
    in_valid = 1'b0;
    while (cyc < t + 4) tick;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check_scoreboard("overrun", 2);
  endtask

  task automatic test_bias;
    logic [15:0] ins[NW] = '{16'h0100, 16'h0100, 16'hFF00, 16'h0200};
    int t;
    set_bias(16'h0A00, LAYER, NEURON + 1);
    set_bias(16'h0B00, LAYER + 1, NEURON);
    send_vector(ins, 0, bias_model, t);
    check_scoreboard("bias filter", 0);
    send_vector(ins, 0, 16'h0300, t);
    tick;
    set_bias(16'h0300, LAYER, NEURON);
    check_scoreboard("bias early write", 0);
    send_vector(ins, 0, bias_model, t);
    tick; tick;
    set_bias(16'hFC00, LAYER, NEURON);
    check_scoreboard("bias same cycle", 0);
    send_vector(ins, 0, bias_model, t);
    check_scoreboard("bias next vector", 0);
  endtask

  task automatic test_mid_reset;
    logic [15:0] ins[NW] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    int t;
    fill_weights(16'h0100);
    in_valid = 1'b1; in_data = 16'h0500;
    tick; tick;
    in_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bias_model = 16'h0000;
    check_scoreboard("mid reset", 0);
    set_bias(16'h0080, LAYER, NEURON);
    send_vector(ins, 0, bias_model, t);
    check_scoreboard("after reset", 0);
    check_value("after reset value", out_r, 16'h0A80);
  endtask

  task automatic test_random;
    logic [15:0] ins[NW];
    int t;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NW; i++) begin
        ins[i]  = 16'($urandom_range(0, 4096)) - 16'd2048;
        wmem[i] = 16'($urandom_range(0, 1024)) - 16'd512;
      end
      set_bias(16'($urandom_range(0, 4096)) - 16'd2048, LAYER, NEURON);
      send_vector(ins, 3, bias_model, t);
      check_scoreboard("random", 0);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    bias_valid = 1'b0; bias_value = '0; cfg_layer = '0; cfg_neuron = '0;
    bias_model = '0;
    fill_weights(16'h0000);
    test_reset();
    test_basic();
    test_sign();
    test_saturate();
    test_gaps();
    test_back_to_back();
    test_overrun();
    test_bias();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
